// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one repeated-addition multiplier datapath (A, B down-counter,
// P accumulator, eqz) between two requesters, with round-robin arbitration.
// Optional feature macro: MSC_ITER_LIMIT_EN. When defined, an iteration counter stops
// the add loop after MAX_ITER additions and flags err together with done.
module mul_share_ctrl #(
    parameter int W        = 16,
    parameter int MAX_ITER = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         eqz,
    input  logic [W-1:0] p_in,
    output logic [W-1:0] data_out,
    output logic         ldA,
    output logic         ldB,
    output logic         ldP,
    output logic         clrP,
    output logic         decB,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] result,
    output logic         err,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDA,
        S_LDB,
        S_CHK,
        S_ADD,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic           last_q, last_d;     // requester served most recently
    logic           cur_q, cur_d;       // requester owning the current operation
    logic [W-1:0]   result_q, result_d;
    logic           lim_hit;
    logic           err_q, err_d;

`ifdef MSC_ITER_LIMIT_EN
    logic [W-1:0]   cnt_q, cnt_d;

    assign lim_hit = (cnt_q == W'(MAX_ITER));
`else
    logic [W-1:0]   unused_max_iter;

    assign unused_max_iter = W'(MAX_ITER);
    assign lim_hit         = 1'b0;
`endif

    // Next-state logic: arbitration in IDLE, add loop until eqz (or iteration limit).
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cur_d    = cur_q;
        result_d = result_q;
        err_d    = err_q;
`ifdef MSC_ITER_LIMIT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Both requesting: the one not served last time wins.
                    if (req0 && req1) begin
                        cur_d = ~last_q;
                    end else begin
                        cur_d = req1;
                    end
                    last_d  = cur_d;
                    err_d   = 1'b0;
                    state_d = S_LDA;
                end
            end
            S_LDA: begin
                state_d = S_LDB;
            end
            S_LDB: begin
`ifdef MSC_ITER_LIMIT_EN
                cnt_d   = '0;
`endif
                state_d = S_CHK;
            end
            S_CHK: begin
                // P is already final here, so the product is captured on entry to RESP
                // and is valid during the done pulse.
                if (eqz) begin
                    result_d = p_in;
                    state_d  = S_RESP;
                end else if (lim_hit) begin
                    result_d = p_in;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
`ifdef MSC_ITER_LIMIT_EN
                cnt_d   = cnt_q + W'(1);
`endif
                state_d = S_CHK;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and control registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            cur_q    <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef MSC_ITER_LIMIT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cur_q    <= cur_d;
            result_q <= result_d;
            err_q    <= err_d;
`ifdef MSC_ITER_LIMIT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Moore output decode: strobes, load bus and handshake depend on state and owner only.
    always_comb begin
        data_out = '0;
        ldA      = 1'b0;
        ldB      = 1'b0;
        ldP      = 1'b0;
        clrP     = 1'b0;
        decB     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        err      = 1'b0;
        busy     = (state_q != S_IDLE);
        gnt0     = busy && !cur_q;
        gnt1     = busy && cur_q;
        case (state_q)
            S_LDA: begin
                data_out = cur_q ? a1 : a0;
                ldA      = 1'b1;
            end
            S_LDB: begin
                data_out = cur_q ? b1 : b0;
                ldB      = 1'b1;
                clrP     = 1'b1;
            end
            S_ADD: begin
                ldP  = 1'b1;
                decB = 1'b1;
            end
            S_RESP: begin
                done0 = !cur_q;
                done1 = cur_q;
                err   = err_q;
            end
            default: begin
            end
        endcase
    end

    assign result = result_q;

endmodule
